// File: rtl/tone_decoder.sv
// Tone decoder: measures rise-to-rise period of an async tone and locks onto one of four bands.
// Latency: valid/code register one clk after the deciding rise; sync adds 3 clk from tone_in.
// Backpressure: none; free-running measurement, outputs hold until the next rise/timeout.
module tone_decoder #(
    parameter int          NOM0    = 381682,
    parameter int          NOM1    = 286534,
    parameter int          NOM2    = 202432,
    parameter int          NOM3    = 151748,
    parameter int          TOL     = 4095,
    parameter logic [19:0] CNT_MAX = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tone_in,
    output logic [3:0]  code,
    output logic        valid,
    output logic        lock_pulse,
    output logic [19:0] period
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LOCK    = 2'd2;

    logic [1:0]  state;
    logic        sync1, sync2, sync3;
    logic        rise;
    logic [19:0] cnt;
    logic [3:0]  cand;
    logic [1:0]  streak;
    logic [3:0]  cls;

    function automatic logic in_band(input logic [19:0] v, input int nom);
        int val;
        val = int'({12'd0, v});
        return (val >= nom - TOL) && (val <= nom + TOL);
    endfunction

    // Edge-only detection: sync2 is never treated as a level.
    assign rise = sync2 & ~sync3;

    always_comb begin
        cls = 4'b0000;
        if (in_band(cnt, NOM0))
            cls = 4'b0001;
        else if (in_band(cnt, NOM1))
            cls = 4'b0010;
        else if (in_band(cnt, NOM2))
            cls = 4'b0100;
        else if (in_band(cnt, NOM3))
            cls = 4'b1000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            cnt        <= 20'd0;
            cand       <= 4'd0;
            streak     <= 2'd0;
            code       <= 4'd0;
            valid      <= 1'b0;
            lock_pulse <= 1'b0;
            period     <= 20'd0;
        end else begin
            sync1      <= tone_in;
            sync2      <= sync1;
            sync3      <= sync2;
            lock_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state  <= MEASURE;
                        cnt    <= 20'd1;
                        cand   <= 4'd0;
                        streak <= 2'd0;
                    end else begin
                        cnt <= 20'd0;
                    end
                end
                MEASURE, LOCK: begin
                    if (rise) begin
                        // A rise on the saturation cycle still wins and records CNT_MAX.
                        period <= cnt;
                        cnt    <= 20'd1;
                        if (state == MEASURE) begin
                            if (cls != 4'd0 && cls == cand && streak == 2'd1) begin
                                state      <= LOCK;
                                code       <= cls;
                                valid      <= 1'b1;
                                lock_pulse <= 1'b1;
                            end else begin
                                cand   <= cls;
                                streak <= {1'b0, cls != 4'd0};
                            end
                        end else if (cls != code) begin
                            state  <= MEASURE;
                            code   <= 4'd0;
                            valid  <= 1'b0;
                            cand   <= cls;
                            streak <= {1'b0, cls != 4'd0};
                        end
                    end else if (cnt == CNT_MAX) begin
                        state  <= IDLE;
                        cnt    <= 20'd0;
                        code   <= 4'd0;
                        valid  <= 1'b0;
                        cand   <= 4'd0;
                        streak <= 2'd0;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder using scaled band nominals and a short saturation count.
// Latency: n/a. Backpressure: n/a.
module tb_tone_decoder;

    localparam int MAXC = 2047;

    logic        clk = 1'b0;
    logic        rst;
    logic        tone_in;
    logic [3:0]  code;
    logic        valid;
    logic        lock_pulse;
    logic [19:0] period;

    int   n_chk  = 0;
    int   n_err  = 0;
    int   lp_cnt = 0;
    int   lp_dbl = 0;
    logic lp_prev = 1'b0;

    tone_decoder #(
        .NOM0(750), .NOM1(550), .NOM2(400), .NOM3(300),
        .TOL(15), .CNT_MAX(20'd2047)
    ) dut (
        .clk(clk), .rst(rst), .tone_in(tone_in), .code(code),
        .valid(valid), .lock_pulse(lock_pulse), .period(period)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (lock_pulse) lp_cnt++;
        if (lock_pulse && lp_prev) lp_dbl++;
        lp_prev = lock_pulse;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic half(input logic lvl, input int n);
        tone_in = lvl;
        repeat (n) step();
    endtask

    task automatic per(input int h1, input int h2);
        half(1'b1, h1);
        half(1'b0, h2);
    endtask

    task automatic hold_low();
        half(1'b0, MAXC + 10);
        check("idle_after_hold", 32'(dut.state), 32'd0);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [3:0] c,
                             input int p, input int lp);
        check({tag, "_valid"},  32'(valid),  32'(v));
        check({tag, "_code"},   32'(code),   32'(c));
        check({tag, "_period"}, 32'(period), 32'(p));
        check({tag, "_lpcnt"},  32'(lp_cnt), 32'(lp));
    endtask

    initial begin
        rst     = 1'b1;
        tone_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tone_in = ~tone_in;
            step();
            check("rst_code", 32'(code), 32'd0);
            check("rst_valid", 32'(valid), 32'd0);
            check("rst_period", 32'(period), 32'd0);
            check("rst_lp", 32'(lock_pulse), 32'd0);
        end
        rst     = 1'b0;
        tone_in = 1'b0;
        step();
        check_out("post_rst", 1'b0, 4'd0, 0, 0);
        check("post_rst_state", 32'(dut.state), 32'd0);
        repeat (5) step();

        // Band 0001 with exact lock latency on the third rise
        per(375, 375);
        per(375, 375);
        tone_in = 1'b1;
        step();
        step();
        check("lat_pre_valid", 32'(valid), 32'd0);
        step();
        check("lat_valid", 32'(valid), 32'd1);
        check("lat_pulse", 32'(lock_pulse), 32'd1);
        check("lat_code", 32'(code), 32'd1);
        check("lat_period", 32'(period), 32'd750);
        step();
        check("lat_pulse_off", 32'(lock_pulse), 32'd0);
        half(1'b1, 375 - 4);
        half(1'b0, 375);
        per(375, 375);
        check_out("b0001", 1'b1, 4'b0001, 750, 1);

        // Switch to band 1000 while locked
        per(150, 150);
        check_out("sw1", 1'b1, 4'b0001, 750, 1);
        per(150, 150);
        check_out("sw2", 1'b0, 4'b0000, 300, 1);
        per(150, 150);
        check_out("sw3", 1'b1, 4'b1000, 300, 2);

        // Out-of-band period never locks
        hold_low();
        for (int i = 0; i < 5; i++) per(250, 250);
        check_out("oob", 1'b0, 4'b0000, 500, 2);

        // Lock 0100, then timeout exactly CNT_MAX counts after the last rise
        per(200, 200);
        per(200, 200);
        tone_in = 1'b1;
        repeat (3) step();
        check("to_lock_valid", 32'(valid), 32'd1);
        check("to_lock_code", 32'(code), 32'd4);
        for (int c = 1; c <= MAXC; c++) begin
            if (c == 197) tone_in = 1'b0;
            step();
            if (c == MAXC - 1) begin
                check("to_pre_valid", 32'(valid), 32'd1);
                check("to_pre_state", 32'(dut.state), 32'd2);
            end
            if (c == MAXC) begin
                check_out("to", 1'b0, 4'b0000, 400, 3);
                check("to_state", 32'(dut.state), 32'd0);
            end
        end

        // Rise on the saturation cycle wins and records CNT_MAX
        tone_in = 1'b1;
        repeat (3) step();
        check("sat_state0", 32'(dut.state), 32'd1);
        for (int c = 1; c <= MAXC; c++) begin
            if (c == 10) tone_in = 1'b0;
            if (c == MAXC - 2) tone_in = 1'b1;
            step();
            if (c == MAXC) begin
                check("sat_period", 32'(period), 32'(MAXC));
                check("sat_state", 32'(dut.state), 32'd1);
                check("sat_valid", 32'(valid), 32'd0);
            end
        end
        hold_low();

        // Alternating bands never lock
        for (int i = 0; i < 3; i++) begin
            per(200, 200);
            per(275, 275);
            check("alt_valid", 32'(valid), 32'd0);
        end
        check("alt_lpcnt", 32'(lp_cnt), 32'd3);
        hold_low();

        // Band edges: nominal-TOL locks, nominal-TOL-1 does not
        for (int i = 0; i < 4; i++) per(193, 192);
        check_out("lo_in", 1'b1, 4'b0100, 385, 4);
        hold_low();
        for (int i = 0; i < 4; i++) per(192, 192);
        check_out("lo_out", 1'b0, 4'b0000, 384, 4);
        for (int i = 0; i < 3; i++) per(283, 282);
        check_out("hi_in", 1'b1, 4'b0010, 565, 5);
        per(283, 283);
        per(283, 283);
        check_out("hi_out", 1'b0, 4'b0000, 566, 5);

        // Silent setting: toggling every clk
        for (int i = 0; i < 20; i++) per(1, 1);
        check_out("silent", 1'b0, 4'b0000, 2, 5);

        // Reset in mid-lock
        for (int i = 0; i < 3; i++) per(150, 150);
        check_out("prelock", 1'b1, 4'b1000, 300, 6);
        rst = 1'b1;
        step();
        check_out("midrst", 1'b0, 4'b0000, 0, 6);
        check("midrst_lp", 32'(lock_pulse), 32'd0);
        check("midrst_state", 32'(dut.state), 32'd0);
        rst = 1'b0;
        step();
        check_out("midrst_after", 1'b0, 4'b0000, 0, 6);
        check("lp_double", 32'(lp_dbl), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
